dsp_mac_ctrl: RTL and testbench
===============================

DSP_MAC_CTRL -- requirements
Module: dsp_mac_ctrl

Interface
REQ-001 Parameter: LEN_W, default 8, width of the product-count field.
REQ-002 Parameter: PIPE_LAT, default 3, cycles from operand on dsp_a/dsp_b to the P-register edge of the attached slice (A1/B1, M, P registers); legal range 2..8.
REQ-003 Ports: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  begin a job when idle; len  in  LEN_W  number of products to accumulate; busy  out  1  job active.
REQ-005 op_valid  in  1; op_ready  out  1; op_a  in  18; op_b  in  18: signed operand stream.
REQ-006 dsp_a  out  18; dsp_b  out  18; dsp_cea  out  1; dsp_ceb  out  1; dsp_cep  out  1; dsp_opmode  out  8; dsp_rstp  out  1; dsp_p  in  48: drive/return of the slice (slice built with OPMODEREG=0).
REQ-007 res_valid  out  1; res_ready  in  1; res_data  out  48 signed sum; res_sat  out  1 saturation flag.

Function
REQ-008 FSM states IDLE, RUN, DRAIN, HOLD.
REQ-009 IDLE: start=1, len>0 -> latch len into remaining counter, go RUN; start=1, len=0 -> res_data=0, go HOLD; otherwise stay.
REQ-010 start is ignored in every state except IDLE.
REQ-011 RUN: op_ready=1; each accept (op_valid&&op_ready) drives dsp_a=op_a, dsp_b=op_b, dsp_cea=dsp_ceb=1 the same cycle and decrements remaining.
REQ-012 Accept with remaining=1 -> DRAIN; op_ready=0 from the next cycle.
REQ-013 Cycles with no accept (bubbles) -> dsp_cea=dsp_ceb=0.
REQ-014 Tag pipeline, depth PIPE_LAT-1, of {valid, first} per cycle; first=1 only for the job's first accept.
REQ-015 Tag at stage PIPE_LAT-1 drives dsp_cep=valid and dsp_opmode = first ? 8'h01 (X=M, Z=0) : 8'h09 (X=M, Z=P); dsp_opmode=8'h00 when valid=0.
REQ-016 Bubbles therefore hold P; result equals the signed sum of exactly len products, independent of stall pattern.
REQ-017 DRAIN: when the last tag's P edge has occurred (PIPE_LAT cycles after the last accept), capture dsp_p into res_data on the next edge, assert res_valid, go HOLD.
REQ-018 HOLD: res_valid=1, res_data stable until res_valid&&res_ready; then -> IDLE, res_valid=0.
REQ-019 busy=1 in RUN, DRAIN and HOLD; 0 in IDLE.
REQ-020 Accept and res_ready never overlap; result latency is PIPE_LAT+1 cycles after the last accept.

Reset
REQ-021 rst=1 at an edge -> IDLE, tag pipeline cleared, counter=0, busy=0, op_ready=0, res_valid=0, res_data=0, res_sat=0, dsp_cea/ceb/cep=0, dsp_opmode=0, dsp_a/b=0.
REQ-022 dsp_rstp = rst, combinational; reset mid-job abandons the job with no res_valid pulse.

Configuration
REQ-023 Macro DSP_MAC_SAT_EN defined: captured P is clamped to the signed 40-bit range [-2^39, 2^39-1], sign-extended to 48 bits; res_sat=1 when clamping occurred.
REQ-024 Macro undefined: res_data = raw dsp_p; res_sat is tied 0; port list is unchanged.

Structure
REQ-025 Shared package holds the FSM state enum, the OPMODE constants (OPM_MUL=8'h01, OPM_MAC=8'h09) and the 40-bit saturation bounds.
REQ-026 One sub-module, dsp_mac_tagpipe: the parameterised {valid, first} shift register.

Verification
REQ-027 Bench uses a behavioural slice model with PIPE_LAT=3.
REQ-028 len=3, a={2,3,4}, b={5,6,7}, back-to-back -> res_data=56, res_valid 4 cycles after the third accept.
REQ-029 Same job, op_valid low 2 cycles between each operand -> res_data=56; dsp_cep low exactly on the bubble-aligned cycles.
REQ-030 len=0 -> res_valid next cycle, res_data=0, no dsp_cea pulse; res_ready held low 5 cycles -> res_data stays 0 and busy=1 until the handshake.
REQ-031 len=4, rst asserted after the 2nd accept -> all outputs at reset values next cycle; a new job len=1, a=-3, b=7 -> res_data=-21.
REQ-032 DSP_MAC_SAT_EN defined, len=40, a=b=-131072 -> res_data=2^39-1, res_sat=1; macro undefined -> res_data=40*2^34, res_sat=0.

Source files
------------

// File: rtl/dsp_mac_ctrl_pkg.sv
// Shared types and constants for the DSP-slice MAC controller.
// Optional build macro DSP_MAC_SAT_EN enables the 40-bit result clamp helper use.
package dsp_mac_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } state_t;

    localparam logic [7:0] OPM_MUL = 8'h01;
    localparam logic [7:0] OPM_MAC = 8'h09;

    localparam logic signed [47:0] SAT_MAX = 48'sh007F_FFFF_FFFF;
    localparam logic signed [47:0] SAT_MIN = 48'shFF80_0000_0000;

    typedef struct packed {
        logic valid;
        logic first;
    } tag_t;

    typedef struct packed {
        logic        sat;
        logic [47:0] data;
    } res_t;

    // Clamp a raw P value into the signed 40-bit window, flagging any clipping.
    function automatic res_t sat_clamp(input logic signed [47:0] p);
        res_t r;
        r.sat  = 1'b0;
        r.data = p;
        if (p > SAT_MAX) begin
            r.sat  = 1'b1;
            r.data = SAT_MAX;
        end else if (p < SAT_MIN) begin
            r.sat  = 1'b1;
            r.data = SAT_MIN;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_mac_ctrl_if.sv
// Bundle of job control, operand stream, DSP slice and result signals.
// master is the controller side, slave is the environment (sources, slice, sink).
interface dsp_mac_ctrl_if #(
    parameter int LEN_W = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    busy;

    logic                    op_valid;
    logic                    op_ready;
    logic signed [17:0]      op_a;
    logic signed [17:0]      op_b;

    logic signed [17:0]      dsp_a;
    logic signed [17:0]      dsp_b;
    logic                    dsp_cea;
    logic                    dsp_ceb;
    logic                    dsp_cep;
    logic [7:0]              dsp_opmode;
    logic                    dsp_rstp;
    logic signed [47:0]      dsp_p;

    logic                    res_valid;
    logic                    res_ready;
    logic signed [47:0]      res_data;
    logic                    res_sat;

    modport master (
        input  start, len, op_valid, op_a, op_b, dsp_p, res_ready,
        output busy, op_ready, dsp_a, dsp_b, dsp_cea, dsp_ceb, dsp_cep,
               dsp_opmode, dsp_rstp, res_valid, res_data, res_sat
    );

    modport slave (
        output start, len, op_valid, op_a, op_b, dsp_p, res_ready,
        input  busy, op_ready, dsp_a, dsp_b, dsp_cea, dsp_ceb, dsp_cep,
               dsp_opmode, dsp_rstp, res_valid, res_data, res_sat
    );

endinterface

// File: rtl/dsp_mac_ctrl_tagpipe.sv
// dsp_mac_tagpipe: {valid, first} shift register that tracks each operand
// through the slice so CEP/OPMODE line up with the cycle its product reaches P.
module dsp_mac_tagpipe
    import dsp_mac_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Drives an external DSP slice (A1/B1, M, P registers) as a stall-tolerant MAC.
// Build macro DSP_MAC_SAT_EN clamps the result to signed 40 bits and sets res_sat.
module dsp_mac_ctrl
    import dsp_mac_ctrl_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input logic            clk,
    input logic            rst,
    dsp_mac_ctrl_if.master bus
);

    state_t           state;
    state_t           next_state;
    logic [LEN_W-1:0] remaining;
    logic             first_pend;
    logic [3:0]       drain_cnt;
    logic             accept;
    logic             capture;
    logic             start_job;
    logic             start_empty;
    tag_t             tag_in;
    tag_t             tag_out;
    res_t             res_next;
    logic [47:0]      res_data_q;
    logic             res_sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DRAIN waits until the last tagged product has landed in P, then captures.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        capture     = 1'b0;
        start_job   = 1'b0;
        start_empty = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        start_job  = 1'b1;
                        next_state = RUN;
                    end else begin
                        start_empty = 1'b1;
                        next_state  = HOLD;
                    end
                end
            end
            RUN: begin
                accept = bus.op_valid;
                if (accept && remaining == LEN_W'(1)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == 4'(PIPE_LAT - 1)) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining  <= '0;
            first_pend <= 1'b0;
            drain_cnt  <= '0;
            res_data_q <= '0;
            res_sat_q  <= 1'b0;
        end else begin
            if (start_job) begin
                remaining  <= bus.len;
                first_pend <= 1'b1;
            end else if (accept) begin
                remaining  <= remaining - LEN_W'(1);
                first_pend <= 1'b0;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
            if (start_empty) begin
                res_data_q <= '0;
                res_sat_q  <= 1'b0;
            end else if (capture) begin
                res_data_q <= res_next.data;
                res_sat_q  <= res_next.sat;
            end
        end
    end

    assign tag_in = '{valid: accept, first: accept && first_pend};

    dsp_mac_tagpipe #(
        .DEPTH (PIPE_LAT - 1)
    ) u_tagpipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

`ifdef DSP_MAC_SAT_EN
    assign res_next = sat_clamp(bus.dsp_p);
`else
    assign res_next = '{sat: 1'b0, data: bus.dsp_p};
`endif

    assign bus.busy       = (state != IDLE);
    assign bus.op_ready   = (state == RUN);
    assign bus.dsp_a      = accept ? bus.op_a : '0;
    assign bus.dsp_b      = accept ? bus.op_b : '0;
    assign bus.dsp_cea    = accept;
    assign bus.dsp_ceb    = accept;
    assign bus.dsp_cep    = tag_out.valid;
    assign bus.dsp_opmode = !tag_out.valid ? 8'h00 : (tag_out.first ? OPM_MUL : OPM_MAC);
    assign bus.dsp_rstp   = rst;
    assign bus.res_valid  = (state == HOLD);
    assign bus.res_data   = res_data_q;
    assign bus.res_sat    = res_sat_q;

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl with a behavioural PIPE_LAT=3 slice and a result scoreboard.
// Expected results follow DSP_MAC_SAT_EN when the bench is built with that macro.
module tb_dsp_mac_ctrl;

    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 3;
    localparam logic signed [47:0] CLAMP_HI = 48'sh007F_FFFF_FFFF;
    localparam logic signed [47:0] CLAMP_LO = 48'shFF80_0000_0000;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    logic signed [17:0] a_tbl [64];
    logic signed [17:0] b_tbl [64];
    logic               hist  [256];
    logic [47:0]        exp_data_q [$];
    logic               exp_sat_q  [$];

    logic signed [17:0] a1;
    logic signed [17:0] b1;
    logic signed [47:0] m;
    logic signed [47:0] p;

    dsp_mac_ctrl_if #(.LEN_W(LEN_W)) bus ();

    dsp_mac_ctrl #(
        .LEN_W    (LEN_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice model: A1/B1 with clock enables, free-running M, P with CEP/OPMODE/RSTP.
    always @(posedge clk) begin
        if (bus.dsp_cea) a1 <= bus.dsp_a;
        if (bus.dsp_ceb) b1 <= bus.dsp_b;
        m <= 48'(a1) * 48'(b1);
        if (bus.dsp_rstp) begin
            p <= '0;
        end else if (bus.dsp_cep) begin
            if (bus.dsp_opmode == 8'h01)      p <= m;
            else if (bus.dsp_opmode == 8'h09) p <= p + m;
        end
    end
    assign bus.dsp_p = p;

    task automatic check_word(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag);
        check_bit({tag, "_busy"},     bus.busy,      1'b0);
        check_bit({tag, "_op_ready"}, bus.op_ready,  1'b0);
        check_bit({tag, "_res_valid"},bus.res_valid, 1'b0);
        check_word({tag, "_res_data"},bus.res_data,  48'd0);
        check_bit({tag, "_res_sat"},  bus.res_sat,   1'b0);
        check_bit({tag, "_cea"},      bus.dsp_cea,   1'b0);
        check_bit({tag, "_ceb"},      bus.dsp_ceb,   1'b0);
        check_bit({tag, "_cep"},      bus.dsp_cep,   1'b0);
        check_word({tag, "_opmode"},  48'(bus.dsp_opmode), 48'd0);
        check_word({tag, "_dsp_a"},   48'(bus.dsp_a), 48'd0);
        check_word({tag, "_dsp_b"},   48'(bus.dsp_b), 48'd0);
    endtask

    // One job: gap bubbles between operands, result held for hold_cycles before accepting it.
    task automatic apply_stimulus(input int n, input int gap, input int hold_cycles, input string tag);
        logic signed [47:0] exp_sum;
        logic               exp_sat;
        logic [47:0]        want;
        logic               acc;
        int                 idx;
        int                 gap_cnt;
        int                 start_cyc;
        int                 last_acc;
        int                 exp_lat;
        bit                 got;

        exp_sum = '0;
        for (int i = 0; i < n; i++) exp_sum += 48'(a_tbl[i]) * 48'(b_tbl[i]);
        exp_sat = 1'b0;
`ifdef DSP_MAC_SAT_EN
        if (exp_sum > CLAMP_HI) begin exp_sum = CLAMP_HI; exp_sat = 1'b1; end
        else if (exp_sum < CLAMP_LO) begin exp_sum = CLAMP_LO; exp_sat = 1'b1; end
`endif
        exp_data_q.push_back(exp_sum);
        exp_sat_q.push_back(exp_sat);

        tick();
        bus.start    = 1'b1;
        bus.len      = LEN_W'(n);
        bus.op_valid = 1'b0;
        #1;
        start_cyc = cyc;
        last_acc  = cyc;
        hist[cyc % 256] = 1'b0;
        check_bit({tag, "_start_cea"}, bus.dsp_cea, 1'b0);

        idx     = 0;
        gap_cnt = 0;
        got     = 0;
        exp_lat = (n > 0) ? PIPE_LAT + 1 : 1;
        for (int k = 0; k < n * (gap + 1) + PIPE_LAT + 8 && !got; k++) begin
            tick();
            bus.start    = 1'b0;
            bus.op_valid = (idx < n) && (gap_cnt == 0);
            if (!bus.op_valid && gap_cnt > 0) gap_cnt--;
            bus.op_a = a_tbl[idx % 64];
            bus.op_b = b_tbl[idx % 64];
            #1;
            acc = bus.op_valid && bus.op_ready;
            hist[cyc % 256] = acc;
            check_bit({tag, "_cea"}, bus.dsp_cea, acc);
            if (acc) begin
                check_word({tag, "_dsp_a"}, 48'(bus.dsp_a), 48'(a_tbl[idx]));
                check_word({tag, "_dsp_b"}, 48'(bus.dsp_b), 48'(b_tbl[idx]));
                idx++;
                gap_cnt  = gap;
                last_acc = cyc;
            end
            if (cyc - (PIPE_LAT - 1) >= start_cyc)
                check_bit({tag, "_cep"}, bus.dsp_cep, hist[(cyc - (PIPE_LAT - 1)) % 256]);
            if (bus.res_valid) begin
                got = 1;
                check_word({tag, "_latency"}, 48'(cyc - last_acc), 48'(exp_lat));
                check_word({tag, "_accepted"}, 48'(idx), 48'(n));
                want = exp_data_q.pop_front();
                check_word({tag, "_res_data"}, bus.res_data, want);
                check_bit({tag, "_res_sat"}, bus.res_sat, exp_sat_q.pop_front());
            end else begin
                check_bit({tag, "_busy"}, bus.busy, 1'b1);
            end
        end
        bus.op_valid = 1'b0;
        check_bit({tag, "_result_seen"}, got, 1'b1);

        for (int k = 0; k < hold_cycles; k++) begin
            tick();
            bus.res_ready = 1'b0;
            #1;
            check_bit({tag, "_hold_valid"}, bus.res_valid, 1'b1);
            check_word({tag, "_hold_data"}, bus.res_data, exp_sum);
            check_bit({tag, "_hold_busy"}, bus.busy, 1'b1);
        end
        tick();
        bus.res_ready = 1'b1;
        #1;
        check_bit({tag, "_hs_valid"}, bus.res_valid, 1'b1);
        tick();
        bus.res_ready = 1'b0;
        #1;
        check_bit({tag, "_after_valid"}, bus.res_valid, 1'b0);
        check_bit({tag, "_after_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 256; i++) hist[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_rstp", bus.dsp_rstp, 1'b1);
        rst = 1'b0;
        tick();
        check_output("reset");
        check_bit("reset_rstp_low", bus.dsp_rstp, 1'b0);

        // start while busy is ignored implicitly; first a plain back-to-back job
        a_tbl[0] = 18'sd2; a_tbl[1] = 18'sd3; a_tbl[2] = 18'sd4;
        b_tbl[0] = 18'sd5; b_tbl[1] = 18'sd6; b_tbl[2] = 18'sd7;
        apply_stimulus(3, 0, 0, "b2b");
        apply_stimulus(3, 2, 0, "stall");
        apply_stimulus(0, 0, 5, "len0");

        a_tbl[3] = -18'sd100; b_tbl[3] = 18'sd9;
        apply_stimulus(4, 1, 1, "mixed");

        // abandon a len=4 job right after its second accept
        tick(); bus.start = 1'b1; bus.len = LEN_W'(4); #1;
        tick(); bus.start = 1'b0; bus.op_valid = 1'b1; bus.op_a = a_tbl[0]; bus.op_b = b_tbl[0]; #1;
        check_bit("abort_acc1", bus.dsp_cea, 1'b1);
        tick(); bus.op_a = a_tbl[1]; bus.op_b = b_tbl[1]; #1;
        check_bit("abort_acc2", bus.dsp_cea, 1'b1);
        tick(); bus.op_valid = 1'b0; rst = 1'b1; #1;
        check_bit("abort_rstp", bus.dsp_rstp, 1'b1);
        tick(); rst = 1'b0; #1;
        check_output("abort");
        for (int k = 0; k < 6; k++) begin
            tick();
            check_bit("abort_no_result", bus.res_valid, 1'b0);
            check_bit("abort_no_cep", bus.dsp_cep, 1'b0);
        end
        a_tbl[0] = -18'sd3; b_tbl[0] = 18'sd7;
        apply_stimulus(1, 0, 0, "post_abort");

        for (int i = 0; i < 40; i++) begin
            a_tbl[i] = -18'sd131072;
            b_tbl[i] = -18'sd131072;
        end
        apply_stimulus(40, 0, 0, "big");

        check_word("scoreboard_empty", 48'(exp_data_q.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
